// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the BCD-to-binary conversion path: FSM states,
// digit limit and an elaboration-time helper.
package bcd2bin_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    // 10**n, used only for the width check on BIN_W
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step of reverse double-dabble:
// digits that reach 8 after the right shift have 3 removed.
module bcd_digit_adjust (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd8) begin
            dout = din - 4'd3;
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift per
// clock, start/busy/done handshake.
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int NDIG  = 3,
    parameter int BIN_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    bin,
    output logic                err
);

    localparam int W     = 4 * NDIG;
    localparam int CNT_W = $clog2(W + 1);
    localparam int CW    = (BIN_W < W) ? BIN_W : W;

    if (!((BIN_W < 64) && ((64'd1 << BIN_W) > (pow10(NDIG) - 64'd1)))) begin : g_width_check
        $error("bcd2bin_seq: BIN_W=%0d too narrow for NDIG=%0d digits", BIN_W, NDIG);
    end

    state_t           state;
    state_t           state_nx;
    logic [W-1:0]     sh_bcd;
    logic [W-1:0]     sh_bin;
    logic [W-1:0]     bcd_shr;
    logic [W-1:0]     bcd_adj;
    logic [W-1:0]     bin_shr;
    logic [CNT_W-1:0] cnt;
    logic             err_i;
    logic             bad_digit;
    logic             last_shift;
    logic [BIN_W-1:0] bin_res;

    assign bcd_shr    = {1'b0, sh_bcd[W-1:1]};
    assign bin_shr    = {sh_bcd[0], sh_bin[W-1:1]};
    assign last_shift = (cnt == CNT_W'(W - 1));

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (bcd_shr[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] > BCD_DIGIT_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Result is taken from the final shift directly, so DONE follows the last shift
    always_comb begin
        bin_res         = '0;
        bin_res[CW-1:0] = bin_shr[CW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (last_shift) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_bcd <= '0;
            sh_bin <= '0;
            cnt    <= '0;
            err_i  <= 1'b0;
            bin    <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh_bcd <= bcd;
                        sh_bin <= '0;
                        cnt    <= '0;
                        err_i  <= bad_digit;
                    end
                end
                S_SHIFT: begin
                    sh_bcd <= bcd_adj;
                    sh_bin <= bin_shr;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_shift) begin
                        bin <= err_i ? '0 : bin_res;
                        err <= err_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq (NDIG=3, BIN_W=12).
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic [11:0] bin;
    logic        err;

    int checks;
    int fails;
    int cyc;

    bcd2bin_seq #(.NDIG(3), .BIN_W(12)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] bcd;
        logic [11:0] exp_bin;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full conversion: accept, wait for done (bounded), check latency and result
    task automatic run_conv(input logic [11:0] b, input logic [11:0] eb, input logic ee,
                            input string nm);
        int  edges;
        bit  seen;
        @(negedge clk);
        bcd   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, " busy_after_accept"}, 32'(busy), 32'd1);
        start = 1'b0;
        bcd   = 12'h555;
        edges = 1;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) seen = 1'b1;
        end
        chk({nm, " done_seen"}, 32'(seen), 32'd1);
        chk({nm, " latency"}, 32'(edges), 32'd13);
        chk({nm, " bin"}, 32'(bin), 32'(eb));
        chk({nm, " err"}, 32'(err), 32'(ee));
        @(posedge clk);
        #1;
        chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
        chk({nm, " idle_busy"}, 32'(busy), 32'd0);
        chk({nm, " bin_held"}, 32'(bin), 32'(eb));
    endtask

    initial begin
        int  ndone;
        int  t1;
        int  t2;
        logic [11:0] b1;
        logic [11:0] b2;
        bit  got_done;

        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        bcd    = '0;

        vecs[0] = '{12'h999, 12'h3E7, 1'b0, "v999"};
        vecs[1] = '{12'h000, 12'h000, 1'b0, "v000"};
        vecs[2] = '{12'h255, 12'h0FF, 1'b0, "v255"};
        vecs[3] = '{12'h100, 12'h064, 1'b0, "v100"};
        vecs[4] = '{12'h9A0, 12'h000, 1'b1, "v9A0_bad"};
        vecs[5] = '{12'h042, 12'h02A, 1'b0, "v042_clears_err"};
        vecs[6] = '{12'h987, 12'h3DB, 1'b0, "v987"};
        vecs[7] = '{12'h00F, 12'h000, 1'b1, "v00F_bad"};
        vecs[8] = '{12'hF00, 12'h000, 1'b1, "vF00_bad"};
        vecs[9] = '{12'h001, 12'h001, 1'b0, "v001"};

        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bin", 32'(bin), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, vecs[i].name);
        end

        // start re-pulsed while busy (edges 3, 13, and the done cycle) is ignored
        @(negedge clk);
        bcd   = 12'h123;
        start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int e = 2; e <= 20; e++) begin
            @(negedge clk);
            if (e == 3 || e == 13 || e == 14) begin
                start = 1'b1;
                bcd   = 12'h456;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                chk("busy_ignore bin", 32'(bin), 32'h07B);
            end
        end
        chk("busy_ignore done_count", 32'(ndone), 32'd1);
        chk("busy_ignore idle", 32'(busy), 32'd0);

        // asynchronous reset mid-conversion
        @(negedge clk);
        bcd   = 12'h789;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst busy", 32'(busy), 32'd0);
        chk("async_rst done", 32'(done), 32'd0);
        chk("async_rst bin", 32'(bin), 32'd0);
        chk("async_rst err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        got_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) got_done = 1'b1;
        end
        chk("async_rst no_done", 32'(got_done), 32'd0);

        // start held high: back-to-back conversions
        @(negedge clk);
        bcd   = 12'h001;
        start = 1'b1;
        ndone = 0;
        t1 = 0;
        t2 = 0;
        b1 = '0;
        b2 = '0;
        for (int e = 0; e < 60 && ndone < 2; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    t1  = cyc;
                    b1  = bin;
                    bcd = 12'h002;
                end else begin
                    t2 = cyc;
                    b2 = bin;
                end
            end
        end
        start = 1'b0;
        chk("held_start done_count", 32'(ndone), 32'd2);
        chk("held_start spacing", 32'(t2 - t1), 32'd14);
        chk("held_start bin1", 32'(b1), 32'd1);
        chk("held_start bin2", 32'(b2), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
